// File: rtl/echo_filter_pkg.sv
// Shared types and default constants for the echo pulse-width filter.
// Holds the FSM state encoding and the default parameter values used by
// echo_filter and echo_ring.
package echo_filter_pkg;

    // Filter state: EMPTY waits for a seed sample, RUN averages the ring.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH         = 32;
    localparam int unsigned DEF_DEPTH_LOG2    = 2;
    localparam int unsigned DEF_MIN_CYCLES    = 100;
    localparam int unsigned DEF_MAX_CYCLES    = 200000;
    localparam int unsigned DEF_STALE_CYCLES  = 1200000;
    localparam int unsigned DEF_OUTLIER_DELTA = 2000;

endpackage

// File: rtl/echo_ring.sv
// Ring buffer of 2^DEPTH_LOG2 samples for the echo filter.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   wr_en_i      - overwrite the oldest entry with wr_data_i, advance pointer
//   seed_en_i    - write wr_data_i to every entry, pointer back to 0
//   wr_data_i    - sample to store
//   oldest_o     - entry that the next write will overwrite
module echo_ring
    import echo_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic             seed_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] oldest_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;

    assign oldest_o = mem_q[ptr_q];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (seed_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = wr_data_i;
            end
            ptr_d = '0;
        end else if (wr_en_i) begin
            mem_d[ptr_q] = wr_data_i;
            ptr_d        = ptr_q + 1'b1;  // wraps modulo DEPTH
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/echo_filter.sv
// Echo pulse-width filter: range check, optional outlier rejection, moving
// average over 2^DEPTH_LOG2 accepted samples, stale-data timeout.
// Optional feature macro: ECHO_OUTLIER_REJECT_EN (outlier rejection in RUN).
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   in_valid    - one-cycle strobe with a new measurement in in_cycles
//   in_cycles   - echo pulse width in clk cycles
//   out_valid   - one-cycle strobe, out_cycles updated (two cycles after input)
//   out_cycles  - moving average of accepted samples
//   out_stale   - no sample accepted for STALE_CYCLES
//   rej_count   - saturating count of rejected samples
module echo_filter
    import echo_filter_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2    = DEF_DEPTH_LOG2,
    parameter int unsigned MIN_CYCLES    = DEF_MIN_CYCLES,
    parameter int unsigned MAX_CYCLES    = DEF_MAX_CYCLES,
    parameter int unsigned STALE_CYCLES  = DEF_STALE_CYCLES,
    parameter int unsigned OUTLIER_DELTA = DEF_OUTLIER_DELTA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_cycles,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_cycles,
    output logic             out_stale,
    output logic [7:0]       rej_count
);

    localparam int unsigned SUM_W  = WIDTH + DEPTH_LOG2;
    localparam int unsigned IDLE_W = $clog2(STALE_CYCLES + 1);

    localparam logic [WIDTH-1:0]  MIN_W   = WIDTH'(MIN_CYCLES);
    localparam logic [WIDTH-1:0]  MAX_W   = WIDTH'(MAX_CYCLES);
    localparam logic [IDLE_W-1:0] STALE_W = IDLE_W'(STALE_CYCLES);

    // Stage 1: registered input sample
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_cycles_q;

    // Stage 2: filter state
    state_e            state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              stale_q, stale_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        rej_q, rej_d;

    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] oldest;
    logic             in_range;
    logic             accept;
    logic             reseed;

    assign avg = sum_q[SUM_W-1:DEPTH_LOG2];

`ifdef ECHO_OUTLIER_REJECT_EN
    localparam logic [WIDTH-1:0] DELTA_W = WIDTH'(OUTLIER_DELTA);

    logic [1:0]       ocnt_q, ocnt_d;
    logic [WIDTH-1:0] diff;
    logic             outlier;

    always_comb begin
        diff    = (s1_cycles_q >= avg) ? (s1_cycles_q - avg) : (avg - s1_cycles_q);
        outlier = (state_q == ST_RUN) && (diff > DELTA_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end
`else
    logic [31:0] unused_delta;
    assign unused_delta = OUTLIER_DELTA;
`endif

    assign in_range = (s1_cycles_q >= MIN_W) && (s1_cycles_q <= MAX_W);

    // Acceptance decision for the sample in stage 1
    always_comb begin
        accept = 1'b0;
        reseed = 1'b0;
`ifdef ECHO_OUTLIER_REJECT_EN
        ocnt_d = ocnt_q;
        if (s1_valid_q && in_range) begin
            if (outlier && (ocnt_q != 2'd2)) begin
                ocnt_d = ocnt_q + 2'd1;
            end else begin
                // Third consecutive outlier reseeds the window at the new level
                accept = 1'b1;
                reseed = (state_q == ST_EMPTY) || outlier;
                ocnt_d = '0;
            end
        end
`else
        if (s1_valid_q && in_range) begin
            accept = 1'b1;
            reseed = (state_q == ST_EMPTY);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        idle_d      = idle_q;
        stale_d     = stale_q;
        out_valid_d = 1'b0;
        rej_d       = rej_q;

        if (s1_valid_q && !accept && (rej_q != 8'hff)) begin
            rej_d = rej_q + 8'd1;
        end

        if (accept) begin
            // Acceptance wins over a coincident stale timeout
            out_valid_d = 1'b1;
            state_d     = ST_RUN;
            idle_d      = '0;
            stale_d     = 1'b0;
            if (reseed) begin
                sum_d = SUM_W'(s1_cycles_q) << DEPTH_LOG2;
            end else begin
                sum_d = sum_q + SUM_W'(s1_cycles_q) - SUM_W'(oldest);
            end
        end else begin
            if (idle_q != STALE_W) begin
                idle_d = idle_q + 1'b1;
            end
            if (idle_d == STALE_W) begin
                stale_d = 1'b1;
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_cycles_q <= '0;
            state_q     <= ST_EMPTY;
            sum_q       <= '0;
            idle_q      <= '0;
            stale_q     <= 1'b1;
            out_valid_q <= 1'b0;
            rej_q       <= '0;
        end else begin
            s1_valid_q  <= in_valid;
            s1_cycles_q <= in_cycles;
            state_q     <= state_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            stale_q     <= stale_d;
            out_valid_q <= out_valid_d;
            rej_q       <= rej_d;
        end
    end

    echo_ring #(
        .WIDTH     (WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (accept && !reseed),
        .seed_en_i(accept && reseed),
        .wr_data_i(s1_cycles_q),
        .oldest_o (oldest)
    );

    assign out_valid  = out_valid_q;
    assign out_cycles = avg;
    assign out_stale  = stale_q;
    assign rej_count  = rej_q;

endmodule

// File: tb/tb_echo_filter.sv
// Directed self-checking bench for echo_filter. STALE_CYCLES is shortened so
// the timeout scenario stays short. Inputs are driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_echo_filter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STALE = 400;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_cycles;
    logic             out_valid;
    logic [WIDTH-1:0] out_cycles;
    logic             out_stale;
    logic [7:0]       rej_count;

    int total = 0;
    int bad   = 0;

    echo_filter #(
        .WIDTH        (WIDTH),
        .DEPTH_LOG2   (2),
        .MIN_CYCLES   (100),
        .MAX_CYCLES   (200000),
        .STALE_CYCLES (STALE),
        .OUTLIER_DELTA(2000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_cycles (in_cycles),
        .out_valid (out_valid),
        .out_cycles(out_cycles),
        .out_stale (out_stale),
        .rej_count (rej_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one sample for one cycle, then checks the two-cycle latency:
    // no strobe on the cycle after input, strobe with the expected average on
    // the cycle after that (or none if exp_ok is 0).
    task automatic send_and_check(input string name, input logic [WIDTH-1:0] v,
                                  input logic exp_ok, input logic [WIDTH-1:0] exp_avg);
        @(negedge clk);
        in_valid  = 1'b1;
        in_cycles = v;
        @(negedge clk);
        in_valid  = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s early_valid got=%b want=0", name, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== exp_ok) begin
            bad++;
            $display("FAIL %s valid got=%b want=%b", name, out_valid, exp_ok);
        end
        total++;
        if (out_cycles !== exp_avg) begin
            bad++;
            $display("FAIL %s avg got=%0d want=%0d", name, out_cycles, exp_avg);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;       // must be ignored while in reset
        in_cycles = 32'd1000;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_cycles, out_stale, rej_count} !== {1'b0, 32'd0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL reset_vals got v=%b c=%0d s=%b r=%0d want v=0 c=0 s=1 r=0",
                     out_valid, out_cycles, out_stale, rej_count);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_ignore cycle=%0d got=%b want=0", i, out_valid);
            end
        end
    endtask

    task automatic test_seed();
        send_and_check("seed", 32'd1000, 1'b1, 32'd1000);
        total++;
        if (out_stale !== 1'b0) begin
            bad++;
            $display("FAIL seed_stale got=%b want=0", out_stale);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL seed_one_cycle got=%b want=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp [4];
        exp[0] = 32'd1250;
        exp[1] = 32'd1500;
        exp[2] = 32'd1750;
        exp[3] = 32'd2000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (k >= 2 && k <= 5) begin
                if (out_valid !== 1'b1 || out_cycles !== exp[k-2]) begin
                    bad++;
                    $display("FAIL b2b k=%0d got v=%b c=%0d want v=1 c=%0d",
                             k, out_valid, out_cycles, exp[k-2]);
                end
            end else if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle k=%0d got=%b want=0", k, out_valid);
            end
            in_valid  = (k < 4);
            in_cycles = 32'd2000;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reject();
        logic seen;
        send_and_check("rej_low", 32'd50, 1'b0, 32'd2000);
        send_and_check("rej_high", 32'd300000, 1'b0, 32'd2000);
        total++;
        if (rej_count !== 8'd2) begin
            bad++;
            $display("FAIL rej_count2 got=%0d want=2", rej_count);
        end
        // Inclusive range edges
        send_and_check("edge_min", 32'd100, 1'b1, 32'd1525);
        send_and_check("edge_max", 32'd200000, 1'b1, 32'd51025);
        send_and_check("edge_below", 32'd99, 1'b0, 32'd51025);
        send_and_check("edge_above", 32'd200001, 1'b0, 32'd51025);
        total++;
        if (rej_count !== 8'd4) begin
            bad++;
            $display("FAIL rej_count4 got=%0d want=4", rej_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            in_valid  = 1'b1;
            in_cycles = 32'd10;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rej_burst_valid got=%b want=0", seen);
        end
        total++;
        if (rej_count !== 8'd255) begin
            bad++;
            $display("FAIL rej_saturate got=%0d want=255", rej_count);
        end
    endtask

    task automatic test_stale();
        int waited;
        // Ring {100,200000,2000,2000}, pointer at 2: 3000 replaces a 2000
        send_and_check("pre_stale", 32'd3000, 1'b1, 32'd51275);
        repeat (STALE - 10) @(negedge clk);
        total++;
        if (out_stale !== 1'b0) begin
            bad++;
            $display("FAIL stale_early got=%b want=0", out_stale);
        end
        waited = 0;
        while (out_stale !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (out_stale !== 1'b1) begin
            bad++;
            $display("FAIL stale_timeout got=%b want=1", out_stale);
        end
        total++;
        if (out_cycles !== 32'd51275) begin
            bad++;
            $display("FAIL stale_hold got=%0d want=51275", out_cycles);
        end
        send_and_check("reseed", 32'd4000, 1'b1, 32'd4000);
        total++;
        if (out_stale !== 1'b0) begin
            bad++;
            $display("FAIL reseed_stale got=%b want=0", out_stale);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid  = 1'b1;
        in_cycles = 32'd500;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, out_cycles, out_stale, rej_count} !== {1'b0, 32'd0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL inflight_rst got v=%b c=%0d s=%b r=%0d want v=0 c=0 s=1 r=0",
                     out_valid, out_cycles, out_stale, rej_count);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL inflight_drop got=%b want=0", out_valid);
            end
        end
    endtask

`ifdef ECHO_OUTLIER_REJECT_EN
    task automatic test_outlier();
        send_and_check("out_seed", 32'd1000, 1'b1, 32'd1000);
        send_and_check("out_rej1", 32'd5000, 1'b0, 32'd1000);
        send_and_check("out_rej2", 32'd5000, 1'b0, 32'd1000);
        send_and_check("out_third", 32'd5000, 1'b1, 32'd5000);
        send_and_check("out_r1", 32'd1000, 1'b0, 32'd5000);
        send_and_check("out_clear", 32'd5000, 1'b1, 32'd5000);
        send_and_check("out_r2", 32'd1000, 1'b0, 32'd5000);
        send_and_check("out_r3", 32'd1000, 1'b0, 32'd5000);
        send_and_check("out_reseed", 32'd1000, 1'b1, 32'd1000);
        total++;
        if (rej_count !== 8'd5) begin
            bad++;
            $display("FAIL out_rej_count got=%0d want=5", rej_count);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cycles = '0;
        test_reset();
        test_seed();
        test_back_to_back();
        test_reject();
        test_stale();
        test_reset_inflight();
`ifdef ECHO_OUTLIER_REJECT_EN
        test_outlier();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
